fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the single write port of Asynchronous_fifo among NUM_REQ requesters in the write-clock domain.
- Round-robin arbitration with bounded bursts: one owner per burst, up to BURST_MAX beats.
- Drives the FIFO w_en/w_data and honours the FIFO full flag as backpressure.
- Sits between the producer blocks and the FIFO write side. No clock-domain crossing inside.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_WIDTH, 4, FIFO data width; must match the FIFO
- BURST_MAX, 4, maximum beats per grant (≥1)
- ID_WIDTH, $clog2(NUM_REQ), width of owner index

Ports:
- w_clk  in  1  write-domain clock, all state on posedge
- w_rst  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NUM_REQ  per-requester valid; held until beat accepted
- req_data  in  NUM_REQ*DATA_WIDTH  packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  marks final beat of requester's packet
- ack  out  NUM_REQ  one-hot; beat of requester i accepted this cycle
- fifo_full  in  1  FIFO full flag (write domain)
- fifo_w_en  out  1  FIFO write enable
- fifo_w_data  out  DATA_WIDTH  FIFO write data
- busy  out  1  high while a burst is owned
- grant_id  out  ID_WIDTH  current/last owner index
- beat_cnt  out  $clog2(BURST_MAX+1)  beats accepted in current burst
- total_writes  out  16  running count of FIFO writes, wraps 0xFFFF→0

Behaviour:
- Reset (w_rst=0, asynchronous): state=IDLE, grant_id=NUM_REQ-1 (so requester 0 wins first), beat_cnt=0, total_writes=0, busy=0. Combinational outputs ack=0, fifo_w_en=0, fifo_w_data=0.
- FSM states are IDLE and BURST.
- IDLE:
  - If any req bit is set, pick the first set bit searching from grant_id+1 upward, modulo NUM_REQ.
  - Register the winner into grant_id, clear beat_cnt, go to BURST.
  - No transfer happens in IDLE, giving 1 cycle of arbitration latency.
  - fifo_full does not block arbitration.
- BURST:
  - xfer = req[grant_id] & ~fifo_full, computed combinationally.
  - fifo_w_en=xfer; fifo_w_data=req_data slice of grant_id, or 0 when xfer=0; ack[grant_id]=xfer.
  - On xfer: beat_cnt+1 and total_writes+1.
  - Return to IDLE on the cycle after the last beat, where the last beat is xfer & (req_last[grant_id] | beat_cnt==BURST_MAX-1).
  - Return to IDLE if req[grant_id]=0; this abandons the burst with no transfer.
  - fifo_full=1 stalls the burst: state held, no ack, no write, beat_cnt held.
- busy = (state==BURST).
- Non-owner requesters never receive ack. Their req is ignored until the next IDLE arbitration.
- grant_id keeps its value in IDLE, so the next search starts after the last owner. This is the fairness rule.
- A single requester with continuous req gets back-to-back bursts separated by one IDLE cycle.
- Reset asserted mid-burst: immediate return to reset values, any in-flight beat is dropped, and the FIFO is reset by the system at the same time.
- The block never writes while fifo_full=1, so no FIFO overflow can originate here.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST}
  - localparam ID_WIDTH
  - localparam BCNT_WIDTH=$clog2(BURST_MAX+1)
  - function rr_pick(req, last_id) returning next owner index
- One natural sub-module, rr_priority_picker: combinational rotate, find-first-set, rotate back. Parameterised on NUM_REQ.
- FSM, counters and muxing stay in fifo_write_arbiter.
- The bench instantiates fifo_write_arbiter driving Asynchronous_fifo (DEPTH=8, w_clk 10 ns, r_clk 17 ns).

Test Plan:
- Single requester: req[2]=1, data 0x3,0x5,0x7 with last on the 3rd beat. Expect grant_id=2 one cycle after req, fifo_w_en high 3 consecutive cycles, FIFO read side returns 3,5,7 in order, total_writes=3.
- Round-robin fairness: all four requesters hold req with 2-beat packets. Expect grant order 0,1,2,3,0, each burst 2 writes, one IDLE cycle between bursts.
- Burst cap: requester 1 sends 6 beats with no last, BURST_MAX=4. Expect 4 writes, then IDLE, then requester 1 regranted (no other req). Expect remaining 2 beats written and 6 total in FIFO order.
- Full backpressure: reader idle, requester 0 sends 10 beats. Expect exactly 8 writes, then fifo_full=1 with ack=0 and fifo_w_en=0 while stalled. After r_en drains 2 entries, beats 9–10 are written and no data is lost or duplicated.
- Abandon: requester 3 drops req after 1 of 3 beats. Expect return to IDLE next cycle, beat_cnt cleared on the next grant, and requester 0 (pending) granted.
- Reset mid-burst: pull w_rst low during beat 2 of a 4-beat burst. Expect fifo_w_en=0, busy=0, total_writes=0, grant_id=3 immediately. After release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// fifo_arb_pkg : shared types, default sizes and round-robin helper
// Revision: 1.0
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int c_num_req_def   = 4;
    localparam int c_burst_max_def = 4;
    localparam int c_id_width      = $clog2(c_num_req_def);
    localparam int c_bcnt_width    = $clog2(c_burst_max_def + 1);

    // Reference form of the owner search: first set bit after last_id, wrapping.
    function automatic logic [c_id_width-1:0] rr_pick(
        input logic [c_num_req_def-1:0] req,
        input logic [c_id_width-1:0]    last_id
    );
        int   idx;
        logic found;
        rr_pick = last_id;
        found   = 1'b0;
        for (int k = 1; k <= c_num_req_def; k++) begin
            idx = (int'(last_id) + k) % c_num_req_def;
            if (!found && (((req >> idx) & c_num_req_def'(1)) != '0)) begin
                rr_pick = c_id_width'(idx);
                found   = 1'b1;
            end
        end
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// rr_priority_picker : rotate, find-first-set, rotate back (combinational)
// Revision: 1.0
// ============================================================================
module rr_priority_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_id,
    output logic                any,
    output logic [ID_WIDTH-1:0] pick
);

    logic [ID_WIDTH:0]   w_start;
    logic [NUM_REQ-1:0]  w_rot;
    logic [ID_WIDTH-1:0] w_ffs;
    logic [ID_WIDTH:0]   w_sum;

    always_comb begin
        w_start = (last_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                : ({1'b0, last_id} + (ID_WIDTH + 1)'(1));
        // Doubling the vector makes the right shift behave as a rotate.
        w_rot   = NUM_REQ'({req, req} >> w_start);
        w_ffs   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_ffs = ID_WIDTH'(j);
            end
        end
        w_sum = w_start + {1'b0, w_ffs};
        if (w_sum >= (ID_WIDTH + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_WIDTH + 1)'(NUM_REQ);
        end
        pick = w_sum[ID_WIDTH-1:0];
        any  = |req;
    end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// fifo_write_arbiter : round-robin, burst-bounded sharing of one FIFO write port
// Revision: 1.0
// ============================================================================
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = c_num_req_def,
    parameter int DATA_WIDTH = 4,
    parameter int BURST_MAX  = c_burst_max_def,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int BCNT_WIDTH = $clog2(BURST_MAX + 1)
) (
    input  logic                          w_clk,
    input  logic                          w_rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [BCNT_WIDTH-1:0]         beat_cnt,
    output logic [15:0]                   total_writes
);

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [BCNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [15:0]           total_writes_q, total_writes_d;

    logic                  w_any;
    logic [ID_WIDTH-1:0]   w_pick;
    logic                  w_xfer;
    logic                  w_last_beat;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req     (req),
        .last_id (grant_id_q),
        .any     (w_any),
        .pick    (w_pick)
    );

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        beat_cnt_d     = beat_cnt_q;
        total_writes_d = total_writes_q;
        ack            = '0;

        w_xfer      = (state_q == BURST) & req[grant_id_q] & ~fifo_full;
        w_last_beat = w_xfer & (req_last[grant_id_q] |
                                (beat_cnt_q == BCNT_WIDTH'(BURST_MAX - 1)));
        fifo_w_en   = w_xfer;
        fifo_w_data = w_xfer ? w_slice[grant_id_q] : '0;
        if (w_xfer) begin
            ack[grant_id_q] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Arbitration ignores fifo_full; a full FIFO only stalls the burst.
                if (w_any) begin
                    grant_id_d = w_pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (w_xfer) begin
                    beat_cnt_d     = beat_cnt_q + 1'b1;
                    total_writes_d = total_writes_q + 16'd1;
                    if (w_last_beat) begin
                        state_d = IDLE;
                    end
                end else if (!req[grant_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state_q        <= IDLE;
            grant_id_q     <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_q     <= '0;
            total_writes_q <= '0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            beat_cnt_q     <= beat_cnt_d;
            total_writes_q <= total_writes_d;
        end
    end

    assign busy         = (state_q == BURST);
    assign grant_id     = grant_id_q;
    assign beat_cnt     = beat_cnt_q;
    assign total_writes = total_writes_q;

endmodule : fifo_write_arbiter
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// tb_fifo_write_arbiter : randomized bench with a behavioural model and a
// behavioural depth-8 FIFO stand-in (w_clk 10 ns, r_clk 17 ns)
// Revision: 1.0
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 4;
    localparam int BMAX  = 4;
    localparam int DEPTH = 8;

    logic              w_clk = 1'b0;
    logic              r_clk = 1'b0;
    logic              w_rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   ack;
    logic              fifo_full;
    logic              fifo_w_en;
    logic [DW-1:0]     fifo_w_data;
    logic              busy;
    logic [1:0]        grant_id;
    logic [2:0]        beat_cnt;
    logic [15:0]       total_writes;

    always #5   w_clk = ~w_clk;
    always #8.5 r_clk = ~r_clk;

    fifo_write_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BMAX)
    ) dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .ack          (ack),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_w_data  (fifo_w_data),
        .busy         (busy),
        .grant_id     (grant_id),
        .beat_cnt     (beat_cnt),
        .total_writes (total_writes)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-requester packet queues: bit 4 = last flag, bits 3:0 = data.
    logic [4:0] pq [NREQ][$];
    bit         hold [NREQ];
    logic [3:0] fifo_q [$];
    logic [3:0] exp_q  [$];
    logic [1:0] glog   [$];
    bit         r_en      = 1'b0;
    bit         rand_mode = 1'b0;
    bit         prev_busy;
    logic [3:0] rd_v;

    // Reference model: owner, beats in burst, burst active, running total.
    bit         m_busy;
    logic [1:0] m_owner;
    int         m_beats;
    int         m_total;

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (pq[i].size() > 0) begin
                req[i]              = !hold[i];
                req_last[i]         = pq[i][0][4];
                req_data[i*DW +: DW] = pq[i][0][3:0];
            end else begin
                req[i]              = 1'b0;
                req_last[i]         = 1'($urandom);
                req_data[i*DW +: DW] = 4'($urandom);
            end
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += pq[i].size();
        return s;
    endfunction

    task automatic step();
        logic [3:0] e_ack, e_data, cap_data;
        logic [1:0] e_owner, cand, nxt;
        bit         e_xfer, cap_wen, found;
        int         len;
        @(negedge w_clk);
        e_owner = m_owner;
        e_xfer  = m_busy && req[m_owner] && !fifo_full;
        e_data  = e_xfer ? req_data[m_owner*DW +: DW] : 4'h0;
        e_ack   = e_xfer ? (4'b0001 << m_owner) : 4'b0000;
        chk("ack",       ack,          e_ack);
        chk("w_en",      fifo_w_en,    e_xfer);
        chk("w_data",    fifo_w_data,  e_data);
        chk("busy",      busy,         m_busy);
        chk("grant_id",  grant_id,     m_owner);
        chk("beat_cnt",  beat_cnt,     m_beats);
        chk("total",     total_writes, m_total);
        cap_wen  = fifo_w_en;
        cap_data = fifo_w_data;
        if (busy && !prev_busy) glog.push_back(grant_id);
        prev_busy = busy;

        if (!m_busy) begin
            if (req != '0) begin
                found = 1'b0;
                nxt   = m_owner;
                for (int k = 1; k <= NREQ; k++) begin
                    cand = 2'((int'(m_owner) + k) % NREQ);
                    if (!found && req[cand]) begin
                        nxt   = cand;
                        found = 1'b1;
                    end
                end
                m_owner = nxt;
                m_beats = 0;
                m_busy  = 1'b1;
            end
        end else if (e_xfer) begin
            m_beats++;
            m_total = (m_total + 1) % 65536;
            if (req_last[m_owner] || m_beats == BMAX) m_busy = 1'b0;
        end else if (!req[m_owner]) begin
            m_busy = 1'b0;
        end

        @(posedge w_clk);
        #1;
        if (cap_wen) begin
            chk("no_overflow", 32'(fifo_q.size() < DEPTH), 1);
            if (fifo_q.size() < DEPTH) fifo_q.push_back(cap_data);
        end
        if (e_xfer) begin
            exp_q.push_back(e_data);
            void'(pq[e_owner].pop_front());
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = int'($urandom_range(1, 6));
                    for (int b = 0; b < len; b++)
                        pq[i].push_back({(b == len - 1) && ($urandom_range(0, 3) != 0),
                                         4'($urandom)});
                end
                hold[i] = ($urandom_range(0, 15) == 0);
            end
        end
        fifo_full = (fifo_q.size() >= DEPTH);
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain();
        r_en = 1'b1;
        for (int k = 0; k < 400 && (fifo_q.size() > 0 || pending() > 0 || m_busy); k++)
            step();
        chk("drain_fifo",  fifo_q.size(), 0);
        chk("drain_exp",   exp_q.size(),  0);
        chk("drain_reqs",  pending(),     0);
    endtask

    task automatic chk_glog(input string tag, input int idx, input int exp);
        chk(tag, (idx < glog.size()) ? 32'(glog[idx]) : 32'hDEAD, exp);
    endtask

    task automatic do_reset();
        w_rst = 1'b0;
        #1;
        chk("rst_ack",   ack,          0);
        chk("rst_w_en",  fifo_w_en,    0);
        chk("rst_wdata", fifo_w_data,  0);
        chk("rst_busy",  busy,         0);
        chk("rst_grant", grant_id,     3);
        chk("rst_bcnt",  beat_cnt,     0);
        chk("rst_total", total_writes, 0);
        m_busy = 1'b0; m_owner = 2'd3; m_beats = 0; m_total = 0;
        prev_busy = 1'b0;
        glog.delete(); fifo_q.delete(); exp_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            pq[i].delete();
            hold[i] = 1'b0;
        end
        fifo_full = 1'b0;
        drive_inputs();
        @(posedge w_clk);
        #2;
        w_rst = 1'b1;
    endtask

    // FIFO read side in the r_clk domain.
    initial begin
        forever begin
            @(posedge r_clk);
            if (r_en && fifo_q.size() > 0) begin
                rd_v = fifo_q.pop_front();
                if (exp_q.size() > 0) chk("fifo_rd", rd_v, exp_q.pop_front());
                else                  chk("fifo_rd_extra", exp_q.size(), 1);
            end
        end
    end

    initial begin
        req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0; w_rst = 1'b1;
        #2;
        do_reset();

        // Single requester, three beats, last on the third.
        pq[2].push_back(5'h03); pq[2].push_back(5'h05); pq[2].push_back(5'h17);
        drive_inputs();
        run(8);
        chk("t1_total", total_writes, 3);
        chk("t1_ngrant", glog.size(), 1);
        chk_glog("t1_owner", 0, 2);
        drain();

        // Round-robin fairness with 2-beat packets; requester 0 has two.
        do_reset();
        r_en = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            pq[i].push_back({1'b0, 4'($urandom)});
            pq[i].push_back({1'b1, 4'($urandom)});
        end
        pq[0].push_back({1'b0, 4'($urandom)});
        pq[0].push_back({1'b1, 4'($urandom)});
        drive_inputs();
        run(40);
        chk("t2_ngrant", glog.size(), 5);
        chk_glog("t2_g0", 0, 0);
        chk_glog("t2_g1", 1, 1);
        chk_glog("t2_g2", 2, 2);
        chk_glog("t2_g3", 3, 3);
        chk_glog("t2_g4", 4, 0);
        chk("t2_total", total_writes, 10);
        drain();

        // Burst cap: six beats without last.
        do_reset();
        r_en = 1'b1;
        for (int b = 0; b < 6; b++) pq[1].push_back({1'b0, 4'(b + 9)});
        drive_inputs();
        run(20);
        chk("t3_ngrant", glog.size(), 2);
        chk_glog("t3_g0", 0, 1);
        chk_glog("t3_g1", 1, 1);
        chk("t3_total", total_writes, 6);
        drain();

        // Full backpressure with the reader idle.
        do_reset();
        r_en = 1'b0;
        for (int b = 0; b < 10; b++) pq[0].push_back({b == 9, 4'(b + 1)});
        drive_inputs();
        run(30);
        chk("t4_total_full", total_writes, 8);
        chk("t4_fifo_lvl",   fifo_q.size(), 8);
        chk("t4_stall_wen",  fifo_w_en, 0);
        chk("t4_stall_ack",  ack, 0);
        drain();
        chk("t4_total_end",  total_writes, 10);

        // Abandon: requester 3 drops after one beat, requester 0 pending.
        do_reset();
        r_en = 1'b1;
        pq[3].push_back(5'h01); pq[3].push_back(5'h02); pq[3].push_back(5'h13);
        drive_inputs();
        for (int k = 0; k < 10 && m_total < 1; k++) step();
        hold[3] = 1'b1;
        pq[0].push_back(5'h0A); pq[0].push_back(5'h1B);
        drive_inputs();
        run(10);
        chk("t5_ngrant", glog.size(), 2);
        chk_glog("t5_g0", 0, 3);
        chk_glog("t5_g1", 1, 0);
        chk("t5_total", total_writes, 3);
        hold[3] = 1'b0;
        pq[3].delete();
        drive_inputs();
        drain();

        // Reset during beat 2 of a 4-beat burst.
        do_reset();
        r_en = 1'b1;
        for (int b = 0; b < 4; b++) pq[2].push_back({b == 3, 4'(b + 4)});
        drive_inputs();
        for (int k = 0; k < 10 && m_total < 1; k++) step();
        chk("t6_busy_pre", busy, 1);
        do_reset();
        pq[0].push_back(5'h1C); pq[2].push_back(5'h1D);
        drive_inputs();
        run(10);
        chk_glog("t6_g0", 0, 0);
        chk_glog("t6_g1", 1, 2);
        drain();

        // Randomized traffic, drops and reader activity.
        do_reset();
        rand_mode = 1'b1;
        repeat (3000) begin
            r_en = ($urandom_range(0, 2) != 0);
            step();
        end
        rand_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
        drive_inputs();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_write_arbiter
`default_nettype wire
